dmem_port_arbiter: RTL

Shares the single-port data memory between two requesters: the pipeline MEM stage (pipe) and the debug/dump unit (dbg). It arbitrates each cycle with pipeline priority and a starvation guard for debug. It also supports a debug lock for burst dumps and returns read data to the requester that issued the read. It sits between the MEM-stage store/load dividers and the data memory, and drives the pipeline stall when the pipeline loses the port.

---
 rtl/dmem_port_arbiter_if.sv | 55 +++++
 rtl/dmem_port_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_if
// Bundles the two requester ports (pipeline MEM stage and debug/dump unit)
// and the single-port data memory port seen by dmem_port_arbiter.
//   pipe*  : pipeline request, strobes, address, write data; grant, stall,
//            read-valid and read data back to the pipeline
//   dbg*   : same for the debug unit, plus dbgLock for burst ownership
//   mem*   : address, write data, byte enables, enable to memory; memDout back
// Modports:
//   slave  : the arbiter
//   master : the environment (requesters + memory)
// -----------------------------------------------------------------------------
interface dmem_port_arbiter_if;
    logic        pipeReq;
    logic [3:0]  pipeWe;
    logic [31:0] pipeAddr;
    logic [31:0] pipeWdata;
    logic        pipeGnt;
    logic        pipeStall;
    logic        pipeRvalid;
    logic [31:0] pipeRdata;

    logic        dbgReq;
    logic [3:0]  dbgWe;
    logic [31:0] dbgAddr;
    logic [31:0] dbgWdata;
    logic        dbgLock;
    logic        dbgGnt;
    logic        dbgRvalid;
    logic [31:0] dbgRdata;

    logic [31:0] memAddr;
    logic [31:0] memDin;
    logic [3:0]  memWe;
    logic        memEn;
    logic [31:0] memDout;

    modport slave (
        input  pipeReq, pipeWe, pipeAddr, pipeWdata,
        output pipeGnt, pipeStall, pipeRvalid, pipeRdata,
        input  dbgReq, dbgWe, dbgAddr, dbgWdata, dbgLock,
        output dbgGnt, dbgRvalid, dbgRdata,
        output memAddr, memDin, memWe, memEn,
        input  memDout
    );

    modport master (
        output pipeReq, pipeWe, pipeAddr, pipeWdata,
        input  pipeGnt, pipeStall, pipeRvalid, pipeRdata,
        output dbgReq, dbgWe, dbgAddr, dbgWdata, dbgLock,
        input  dbgGnt, dbgRvalid, dbgRdata,
        input  memAddr, memDin, memWe, memEn,
        output memDout
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single-port data memory between the pipeline MEM stage and the
// debug/dump unit. Pipeline has priority; debug gets forced priority after
// MAX_WAIT consecutive refusals. dbgLock holds the port for debug bursts.
// Read data is steered back to whichever requester issued the read.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : dmem_port_arbiter_if.slave (pipe/dbg requester ports, memory port)
// Parameters:
//   READ_LATENCY : cycles from a granted read to memDout valid (1..4)
//   MAX_WAIT     : refusals tolerated before debug is forced through (1..15)
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int MAX_WAIT     = 4
) (
    input  logic               clk,
    input  logic               reset,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic [0:0] {
        ARB      = 1'b0,
        DBG_LOCK = 1'b1
    } arbState_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    arbState_t                state;
    logic [3:0]               waitCnt;
    logic                     waitExpired;
    logic                     pipeGnt;
    logic                     dbgGnt;
    logic                     rdIssue;
    logic [READ_LATENCY-1:0]  rdVldSr;
    logic [READ_LATENCY-1:0]  rdOwnSr;
    logic                     tailPipe;
    logic                     tailDbg;
    logic [31:0]              pipeRdHold;
    logic [31:0]              dbgRdHold;

    assign waitExpired = (waitCnt == WAIT_LIMIT);

    // Grant decision: pipeline wins ties until debug has waited MAX_WAIT cycles.
    always_comb begin
        pipeGnt = 1'b0;
        dbgGnt  = 1'b0;
        if (!reset) begin
            if (state == ARB) begin
                dbgGnt  = bus.dbgReq & (~bus.pipeReq | waitExpired);
                pipeGnt = bus.pipeReq & ~dbgGnt;
            end else begin
                dbgGnt  = bus.dbgReq;
            end
        end
    end

    assign bus.pipeGnt   = pipeGnt;
    assign bus.dbgGnt    = dbgGnt;
    assign bus.pipeStall = ~reset & bus.pipeReq & ~pipeGnt;

    assign bus.memEn   = pipeGnt | dbgGnt;
    assign bus.memAddr = pipeGnt ? bus.pipeAddr  : (dbgGnt ? bus.dbgAddr  : 32'h0);
    assign bus.memDin  = pipeGnt ? bus.pipeWdata : (dbgGnt ? bus.dbgWdata : 32'h0);
    assign bus.memWe   = pipeGnt ? bus.pipeWe    : (dbgGnt ? bus.dbgWe    : 4'h0);

    assign rdIssue = (pipeGnt && bus.pipeWe == 4'h0) || (dbgGnt && bus.dbgWe == 4'h0);

    // Arbitration state and debug starvation counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ARB;
            waitCnt <= 4'h0;
        end else begin
            case (state)
                ARB:      if (dbgGnt && bus.dbgLock) state <= DBG_LOCK;
                DBG_LOCK: if (!bus.dbgLock)          state <= ARB;
                default:                             state <= ARB;
            endcase
            if (dbgGnt || !bus.dbgReq) begin
                waitCnt <= 4'h0;
            end else if (!waitExpired) begin
                waitCnt <= waitCnt + 4'd1;
            end
        end
    end

    // Read-return tracker: one slot per cycle of memory latency, so the tail
    // lines up with memDout for the read issued READ_LATENCY cycles earlier.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdVldSr <= '0;
            rdOwnSr <= '0;
        end else begin
            rdVldSr[0] <= rdIssue;
            rdOwnSr[0] <= dbgGnt;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rdVldSr[i] <= rdVldSr[i-1];
                rdOwnSr[i] <= rdOwnSr[i-1];
            end
        end
    end

    assign tailPipe = ~reset & rdVldSr[READ_LATENCY-1] & ~rdOwnSr[READ_LATENCY-1];
    assign tailDbg  = ~reset & rdVldSr[READ_LATENCY-1] &  rdOwnSr[READ_LATENCY-1];

    // Last returned word per requester, shown while its rvalid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipeRdHold <= 32'h0;
            dbgRdHold  <= 32'h0;
        end else begin
            if (tailPipe) pipeRdHold <= bus.memDout;
            if (tailDbg)  dbgRdHold  <= bus.memDout;
        end
    end

    assign bus.pipeRvalid = tailPipe;
    assign bus.dbgRvalid  = tailDbg;
    assign bus.pipeRdata  = reset ? 32'h0 : (tailPipe ? bus.memDout : pipeRdHold);
    assign bus.dbgRdata   = reset ? 32'h0 : (tailDbg  ? bus.memDout : dbgRdHold);

    a_oneGrant:  assert property (@(posedge clk) !(pipeGnt && dbgGnt));
    a_pipeOwned: assert property (@(posedge clk) pipeGnt |-> bus.pipeReq);
    a_dbgOwned:  assert property (@(posedge clk) dbgGnt  |-> bus.dbgReq);
endmodule
